seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is displayed (legal >= 2).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, seg and dp are inverted at the output.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 0; when 1, an is inverted at the output.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  scanning enable.
REQ-008 SHALL have port load  input  1  one-cycle write strobe for digits_in/dp_in.
REQ-009 SHALL have port digits_in  input  4*NUM_DIGITS  BCD/hex nibbles; nibble k is digit k, digit 0 is rightmost.
REQ-010 SHALL have port dp_in  input  NUM_DIGITS  decimal-point per digit.
REQ-011 SHALL have port hex_mode  input  1  1 = decode 10..15 as A..F; 0 = blank them.
REQ-012 SHALL have port lzb_en  input  1  leading-zero blanking enable.
REQ-013 SHALL have port seg  output  7  segments {a,b,c,d,e,f,g}, registered.
REQ-014 SHALL have port dp  output  1  decimal point of the selected digit, registered.
REQ-015 SHALL have port an  output  NUM_DIGITS  one-hot digit select, registered.
REQ-016 SHALL have port pending  output  1  loaded data not yet displayed.
REQ-017 SHALL have port frame_start  output  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-018 Scan counter SHALL count 0..SCAN_DIV-1 while enable=1 and hold while enable=0.
REQ-019 At terminal count, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0; frame_start SHALL be 1 in the cycle after the wrap edge only.
REQ-020 seg/dp/an SHALL reflect current index and active register with exactly 1 cycle latency.
REQ-021 Active-high decode SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-022 With hex_mode=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; with hex_mode=0, nibbles 10..15 SHALL yield 0000000.
REQ-023 With lzb_en=1, digit k (k>=1) SHALL be blanked (seg=0000000) when it and all digits above it are 0; digit 0 SHALL never be blanked; dp SHALL still follow dp_in of the active register.
REQ-024 load=1 SHALL write digits_in/dp_in into a pending register and set pending=1 next cycle; repeated loads SHALL overwrite (last wins).
REQ-025 Pending data SHALL be copied to the active register on the edge where index wraps to 0 (no tearing mid-frame), clearing pending.
REQ-026 load coincident with the wrap edge: old pending data SHALL be applied, new data SHALL be stored in pending and pending SHALL remain 1.
REQ-027 While enable=0: an all inactive, seg and dp off, index and counter held; pending data SHALL transfer to active on the next edge.
REQ-028 Polarity inversion SHALL apply after all decode/blanking; "off"/"inactive" means logic 0 before inversion.

Reset
REQ-029 rst_n=0 sampled on a clock edge SHALL clear counter, index, active and pending registers to 0, pending=0, frame_start=0, an inactive, seg and dp off, regardless of load/enable.
REQ-030 Reset mid-frame or with pending=1 SHALL discard pending data; first display update SHALL appear 1 cycle after rst_n returns to 1 with enable=1 (digit 0 showing 0, seg=1111110, an=0001).

Verification (NUM_DIGITS=4, SCAN_DIV=4, polarities 0)
REQ-031 Reset, enable=1, no load -> an cycles 0001,0010,0100,1000 every 4 cycles, seg=1111110, frame_start pulses every 16 cycles.
REQ-032 load digits_in=16'h1234, dp_in=4'b0100 mid-frame -> pending=1, display unchanged until wrap; next frame digit0 seg=0110011, digit2 seg=1101101 with dp=1; pending=0.
REQ-033 digits_in=16'h00A5, hex_mode=0 then 1, lzb_en=1 -> digits 3,2 blank; digit1 0000000 then 1110111; digit0 1011011.
REQ-034 load asserted on wrap edge with prior pending 16'h1111, new 16'h2222 -> frame shows 1111, pending stays 1, following frame shows 2222.
REQ-035 enable=0 for 10 cycles mid-digit -> an=0000, seg=0000000, index held; on re-enable scanning resumes same digit with remaining count.
REQ-036 rst_n=0 for one cycle with pending=1 -> all outputs off, pending=0, old pending data never displayed.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed 7-segment display scanner with double-buffered digit data.
// Ports: clk, rst_n (sync, active-low); enable scans; load strobes digits_in/dp_in into the pending buffer;
// hex_mode shows 10..15 as A..F; lzb_en blanks leading zeros; seg/dp/an are registered drive outputs;
// pending flags buffered data not yet shown; frame_start pulses after the index wraps to digit 0.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d, pnd_q, pnd_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d, an_q, an_d, blank;
  logic [6:0] seg_q, seg_d;
  logic pending_q, pending_d, fs_q, fs_d, dp_q, dp_d;
  logic tc, wrap, xfer, zero_run;
  logic [3:0] nib;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return (n > 4'd9 && !hex) ? 7'b0 : s;
  endfunction

  always_comb begin
    zero_run = 1'b1;
    blank = '0;
    // Walk from the most significant digit down; a digit is blankable while every digit above it is zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (act_q[4*k +: 4] == 4'd0);
      blank[k] = lzb_en & zero_run & (k != 0);
    end
    nib = act_q[4*idx_q +: 4];
    tc = enable && cnt_q == CW'(SCAN_DIV - 1);
    wrap = tc && idx_q == IW'(NUM_DIGITS - 1);
    // Buffered data goes live only at a frame boundary, or immediately while the display is dark.
    xfer = pending_q && (wrap || !enable);
    cnt_d = !enable ? cnt_q : tc ? '0 : cnt_q + 1'b1;
    idx_d = !tc ? idx_q : wrap ? '0 : idx_q + 1'b1;
    act_d = xfer ? pnd_q : act_q;
    act_dp_d = xfer ? pnd_dp_q : act_dp_q;
    pnd_d = load ? digits_in : pnd_q;
    pnd_dp_d = load ? dp_in : pnd_dp_q;
    pending_d = load | (pending_q & ~xfer);
    fs_d = wrap;
    seg_d = (enable && !blank[idx_q]) ? decode(nib, hex_mode) : 7'b0;
    dp_d = enable & act_dp_q[idx_q];
    an_d = enable ? NUM_DIGITS'(1) << idx_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      act_q <= '0;
      act_dp_q <= '0;
      pnd_q <= '0;
      pnd_dp_q <= '0;
      pending_q <= 1'b0;
      fs_q <= 1'b0;
      seg_q <= '0;
      dp_q <= 1'b0;
      an_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_q <= act_d;
      act_dp_q <= act_dp_d;
      pnd_q <= pnd_d;
      pnd_dp_q <= pnd_dp_d;
      pending_q <= pending_d;
      fs_q <= fs_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end

  assign seg = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp = dp_q ^ SEG_ACTIVE_LOW;
  assign an = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  assign pending = pending_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed stimulus, per-cycle comparison against a tick-count model plus literal pins.
module tb_seven_seg_scan_driver;
  localparam int N = 4;
  localparam int SD = 4;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0, hex_mode = 1'b0, lzb_en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic pending, frame_start;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .lzb_en(lzb_en), .seg(seg), .dp(dp), .an(an), .pending(pending),
    .frame_start(frame_start)
  );

  logic [6:0] tab [16];
  int ticks = 0;
  logic [15:0] m_act = '0, m_pnd = '0;
  logic [3:0] m_act_dp = '0, m_pnd_dp = '0;
  logic m_pf = 1'b0, m_wrap;
  logic [6:0] e_seg = '0;
  logic [3:0] e_an = '0;
  logic e_dp = 1'b0, e_pend = 1'b0, e_fs = 1'b0;

  initial begin
    tab[0] = 7'b1111110; tab[1] = 7'b0110000; tab[2] = 7'b1101101; tab[3] = 7'b1111001;
    tab[4] = 7'b0110011; tab[5] = 7'b1011011; tab[6] = 7'b1011111; tab[7] = 7'b1110000;
    tab[8] = 7'b1111111; tab[9] = 7'b1111011; tab[10] = 7'b1110111; tab[11] = 7'b0011111;
    tab[12] = 7'b1001110; tab[13] = 7'b0111101; tab[14] = 7'b1001111; tab[15] = 7'b1000111;
  end

  function automatic logic [6:0] seg_for(input int k);
    int lead = -1;
    int v = int'(m_act[4*k +: 4]);
    for (int i = 0; i < N; i++) if (m_act[4*i +: 4] != 4'd0) lead = i;
    if (lzb_en && k > 0 && k > lead) return 7'b0;
    if (v > 9 && !hex_mode) return 7'b0;
    return tab[v];
  endfunction

  always @(posedge clk) begin : model
    int k;
    if (!rst_n) begin
      ticks = 0; m_act = '0; m_pnd = '0; m_act_dp = '0; m_pnd_dp = '0; m_pf = 1'b0;
      e_seg = '0; e_an = '0; e_dp = 1'b0; e_pend = 1'b0; e_fs = 1'b0;
    end else begin
      k = (ticks / SD) % N;
      m_wrap = enable && (ticks % (SD * N)) == SD * N - 1;
      e_seg = enable ? seg_for(k) : 7'b0;
      e_an = enable ? 4'(1 << k) : 4'b0;
      e_dp = enable && m_act_dp[k];
      e_fs = m_wrap;
      if (m_pf && (m_wrap || !enable)) begin
        m_act = m_pnd; m_act_dp = m_pnd_dp; m_pf = 1'b0;
      end
      if (load) begin
        m_pnd = digits_in; m_pnd_dp = dp_in; m_pf = 1'b1;
      end
      e_pend = m_pf;
      if (enable) ticks++;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0b want %0b at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("seg", 32'(seg), 32'(e_seg));
    cmp("dp", 32'(dp), 32'(e_dp));
    cmp("an", 32'(an), 32'(e_an));
    cmp("pending", 32'(pending), 32'(e_pend));
    cmp("frame_start", 32'(frame_start), 32'(e_fs));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] pats [4];
    pats[0] = 16'h6789; pats[1] = 16'hBCDE; pats[2] = 16'hF00F; pats[3] = 16'h0000;
    tick(2);
    cmp("rst_seg", 32'(seg), 0); cmp("rst_an", 32'(an), 0); cmp("rst_pend", 32'(pending), 0);
    rst_n = 1'b1; enable = 1'b1;
    tick(1);
    cmp("first_seg", 32'(seg), 32'b1111110); cmp("first_an", 32'(an), 32'b0001);
    tick(4);
    cmp("scan_an1", 32'(an), 32'b0010);
    tick(11);
    cmp("wrap_fs", 32'(frame_start), 1); cmp("wrap_an3", 32'(an), 32'b1000);
    tick(1);
    cmp("fs_clear", 32'(frame_start), 0); cmp("an_back0", 32'(an), 32'b0001);
    load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
    tick(1);
    load = 1'b0;
    cmp("pend_set", 32'(pending), 1); cmp("no_tear", 32'(seg), 32'b1111110);
    tick(15);
    cmp("d0_4", 32'(seg), 32'b0110011); cmp("pend_clr", 32'(pending), 0); cmp("d0_dp", 32'(dp), 0);
    tick(8);
    cmp("d2_2", 32'(seg), 32'b1101101); cmp("d2_dp", 32'(dp), 1); cmp("d2_an", 32'(an), 32'b0100);
    load = 1'b1; digits_in = 16'h00A5; dp_in = 4'b0000; lzb_en = 1'b1;
    tick(1);
    load = 1'b0;
    tick(7);
    cmp("a5_d0", 32'(seg), 32'b1011011);
    tick(4);
    cmp("a5_d1_nohex", 32'(seg), 0); cmp("a5_d1_an", 32'(an), 32'b0010);
    hex_mode = 1'b1;
    tick(1);
    cmp("a5_d1_hex", 32'(seg), 32'b1110111);
    tick(4);
    cmp("a5_d2_blank", 32'(seg), 0); cmp("a5_d2_an", 32'(an), 32'b0100);
    tick(4);
    cmp("a5_d3_blank", 32'(seg), 0);
    load = 1'b1; digits_in = 16'h1111;
    tick(1);
    digits_in = 16'h2222;
    tick(1);
    load = 1'b0;
    cmp("wrapload_pend", 32'(pending), 1); cmp("wrapload_fs", 32'(frame_start), 1);
    tick(1);
    cmp("old_applied", 32'(seg), 32'b0110000);
    tick(16);
    cmp("new_applied", 32'(seg), 32'b1101101); cmp("new_pend_clr", 32'(pending), 0);
    enable = 1'b0; load = 1'b1; digits_in = 16'h9999;
    tick(1);
    load = 1'b0;
    tick(9);
    cmp("dis_an", 32'(an), 0); cmp("dis_seg", 32'(seg), 0); cmp("dis_pend", 32'(pending), 0);
    enable = 1'b1;
    tick(1);
    cmp("resume_an", 32'(an), 32'b0001); cmp("resume_seg", 32'(seg), 32'b1111011);
    tick(3);
    cmp("resume_count", 32'(an), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; digits_in = pats[i]; dp_in = 4'(i * 5); hex_mode = i[0];
      tick(1);
      load = 1'b0;
      tick(20);
    end
    load = 1'b1; digits_in = 16'h8888;
    tick(1);
    load = 1'b0;
    cmp("pre_rst_pend", 32'(pending), 1);
    rst_n = 1'b0;
    tick(1);
    cmp("mid_rst_seg", 32'(seg), 0); cmp("mid_rst_an", 32'(an), 0); cmp("mid_rst_pend", 32'(pending), 0);
    rst_n = 1'b1;
    tick(1);
    cmp("post_rst_seg", 32'(seg), 32'b1111110); cmp("post_rst_an", 32'(an), 32'b0001);
    tick(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
